// File: rtl/ast_rr_mux.sv
// Packet-level round-robin merge of TX_DIR Avalon-ST streams into one stream.
// A grant is held from the first accepted beat until an eop beat, so packets never interleave.
module ast_rr_mux #(
  parameter int DATA_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 10,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
  parameter int TX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR)
) (
  input  logic                     clk_i,
  input  logic                     srst_i,

  input  logic [DATA_WIDTH-1:0]    ast_data_i          [TX_DIR],
  input  logic                     ast_startofpacket_i [TX_DIR],
  input  logic                     ast_endofpacket_i   [TX_DIR],
  input  logic                     ast_valid_i         [TX_DIR],
  input  logic [EMPTY_WIDTH-1:0]   ast_empty_i         [TX_DIR],
  input  logic [CHANNEL_WIDTH-1:0] ast_channel_i       [TX_DIR],
  output logic                     ast_ready_o         [TX_DIR],

  output logic [DATA_WIDTH-1:0]    ast_data_o,
  output logic                     ast_startofpacket_o,
  output logic                     ast_endofpacket_o,
  output logic                     ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
  output logic [DIR_SEL_WIDTH-1:0] dir_o,
  input  logic                     ast_ready_i
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [DIR_SEL_WIDTH-1:0] grant;
  logic [DIR_SEL_WIDTH-1:0] grant_next;
  logic [DIR_SEL_WIDTH-1:0] last_grant;
  logic [DIR_SEL_WIDTH-1:0] last_grant_next;

  logic                     scan_found;
  logic [DIR_SEL_WIDTH-1:0] scan_pick;
  int                       cand;

  logic                     out_free;
  logic                     accept;

  logic                     sel_valid;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     sel_sop;
  logic                     sel_eop;
  logic [EMPTY_WIDTH-1:0]   sel_empty;
  logic [CHANNEL_WIDTH-1:0] sel_channel;

  // The output register can take a new beat when it is empty or draining this cycle.
  assign out_free = !ast_valid_o || ast_ready_i;
  assign accept   = (state == LOCKED) && sel_valid && out_free;

  always_comb begin
    for (int k = 0; k < TX_DIR; k++) begin
      ast_ready_o[k] = (state == LOCKED) && (grant == DIR_SEL_WIDTH'(k)) && out_free;
    end
  end

  always_comb begin
    sel_valid   = 1'b0;
    sel_data    = '0;
    sel_sop     = 1'b0;
    sel_eop     = 1'b0;
    sel_empty   = '0;
    sel_channel = '0;
    for (int k = 0; k < TX_DIR; k++) begin
      if (grant == DIR_SEL_WIDTH'(k)) begin
        sel_valid   = ast_valid_i[k];
        sel_data    = ast_data_i[k];
        sel_sop     = ast_startofpacket_i[k];
        sel_eop     = ast_endofpacket_i[k];
        sel_empty   = ast_empty_i[k];
        sel_channel = ast_channel_i[k];
      end
    end
  end

  // Scan starts just after the previous winner, so the most recent grant has lowest priority.
  always_comb begin
    scan_found = 1'b0;
    scan_pick  = '0;
    cand       = 0;
    for (int i = 0; i < TX_DIR; i++) begin
      cand = (int'(last_grant) + 1 + i) % TX_DIR;
      if (!scan_found && ast_valid_i[cand]) begin
        scan_found = 1'b1;
        scan_pick  = DIR_SEL_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (scan_found) begin
          grant_next      = scan_pick;
          last_grant_next = scan_pick;
          state_next      = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && sel_eop) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= DIR_SEL_WIDTH'(TX_DIR - 1);
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  // A new beat overwrites a draining one; otherwise a drained beat clears valid and a stalled one holds.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ast_data_o          <= '0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_valid_o         <= 1'b0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
      dir_o               <= '0;
    end else if (accept) begin
      ast_data_o          <= sel_data;
      ast_startofpacket_o <= sel_sop;
      ast_endofpacket_o   <= sel_eop;
      ast_valid_o         <= 1'b1;
      ast_empty_o         <= sel_empty;
      ast_channel_o       <= sel_channel;
      dir_o               <= grant;
    end else if (ast_valid_o && ast_ready_i) begin
      ast_valid_o         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ast_rr_mux.sv
// Directed and randomized self-checking bench for ast_rr_mux (4 inputs, 64-bit data).
// Inputs are driven 1 ns after the rising edge; outputs and handshakes are sampled on the falling edge.
module tb_ast_rr_mux;

  localparam int DW = 64;
  localparam int CW = 10;
  localparam int EW = 3;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst_i;
  logic [DW-1:0] ast_data_i          [N];
  logic          ast_startofpacket_i [N];
  logic          ast_endofpacket_i   [N];
  logic          ast_valid_i         [N];
  logic [EW-1:0] ast_empty_i         [N];
  logic [CW-1:0] ast_channel_i       [N];
  logic          ast_ready_o         [N];
  logic [DW-1:0] ast_data_o;
  logic          ast_startofpacket_o;
  logic          ast_endofpacket_o;
  logic          ast_valid_o;
  logic [EW-1:0] ast_empty_o;
  logic [CW-1:0] ast_channel_o;
  logic [SW-1:0] dir_o;
  logic          ast_ready_i;

  ast_rr_mux #(
    .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .EMPTY_WIDTH(EW), .TX_DIR(N), .DIR_SEL_WIDTH(SW)
  ) dut (
    .clk_i(clk), .srst_i(srst_i),
    .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
    .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i), .ast_ready_o(ast_ready_o),
    .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o(ast_endofpacket_o), .ast_valid_o(ast_valid_o),
    .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o), .dir_o(dir_o),
    .ast_ready_i(ast_ready_i)
  );

  typedef struct packed {
    logic          idle;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [CW-1:0] channel;
  } beat_t;

  typedef struct {
    beat_t b;
    int    dir;
    int    cyc;
  } rec_t;

  beat_t src_q [N][$];
  beat_t exp_q [N][$];
  rec_t  out_log[$];
  logic  acc        [N];
  logic  drove_idle [N];
  int    cyc;
  int    checks;
  int    errors;

  function automatic beat_t mk(logic [DW-1:0] d, logic s, logic e, logic [EW-1:0] em, logic [CW-1:0] ch);
    mk = '{idle: 1'b0, data: d, sop: s, eop: e, empty: em, channel: ch};
  endfunction

  function automatic beat_t gap_beat();
    gap_beat = '{idle: 1'b1, data: '0, sop: 1'b0, eop: 1'b0, empty: '0, channel: '0};
  endfunction

  // One clock: record handshakes at the falling edge, then advance each source after the rising edge.
  task automatic step();
    beat_t f;
    @(negedge clk);
    for (int k = 0; k < N; k++) acc[k] = ast_valid_i[k] && ast_ready_o[k];
    if (ast_valid_o === 1'b1 && ast_ready_i === 1'b1)
      out_log.push_back('{b: mk(ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o),
                          dir: int'(dir_o), cyc: cyc});
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0 && (acc[k] || drove_idle[k])) void'(src_q[k].pop_front());
      if (src_q[k].size() > 0) begin
        f = src_q[k][0];
        ast_valid_i[k]         = !f.idle;
        drove_idle[k]          = f.idle;
        ast_data_i[k]          = f.data;
        ast_startofpacket_i[k] = f.sop;
        ast_endofpacket_i[k]   = f.eop;
        ast_empty_i[k]         = f.empty;
        ast_channel_i[k]       = f.channel;
      end else begin
        ast_valid_i[k] = 1'b0;
        drove_idle[k]  = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    srst_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    repeat (2) step();
    srst_i = 1'b0;
    out_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ast_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ast_valid_o); end
    checks++; if (ast_data_o !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", ast_data_o); end
    checks++; if ({ast_startofpacket_o, ast_endofpacket_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_sop_eop: got %b%b expected 00", ast_startofpacket_o, ast_endofpacket_o); end
    checks++; if ({ast_empty_o, ast_channel_o, dir_o} !== '0) begin errors++; $display("[TB] FAIL reset_empty_channel_dir: got %h/%h/%h expected 0/0/0", ast_empty_o, ast_channel_o, dir_o); end
    for (int k = 0; k < N; k++) begin
      checks++; if (ast_ready_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready[%0d]: got %b expected 0", k, ast_ready_o[k]); end
    end
  endtask

  task automatic test_single_packet();
    int c0;
    beat_t e;
    src_q[2].push_back(mk(64'hA0, 1'b1, 1'b0, 3'd0, 10'd5));
    src_q[2].push_back(mk(64'hA1, 1'b0, 1'b0, 3'd0, 10'd5));
    src_q[2].push_back(mk(64'hA2, 1'b0, 1'b1, 3'd3, 10'd5));
    step();
    c0 = cyc;
    for (int t = 0; t < 30 && out_log.size() < 3; t++) step();
    checks++; if (out_log.size() != 3) begin errors++; $display("[TB] FAIL single_count: got %0d beats expected 3", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 3; i++) begin
      e = mk(64'hA0 + 64'(i), i == 0, i == 2, (i == 2) ? 3'd3 : 3'd0, 10'd5);
      checks++; if (out_log[i].b !== e) begin errors++; $display("[TB] FAIL single_beat%0d: got %h expected %h", i, out_log[i].b, e); end
      checks++; if (out_log[i].dir != 2) begin errors++; $display("[TB] FAIL single_dir%0d: got %0d expected 2", i, out_log[i].dir); end
      checks++; if (out_log[i].cyc != c0 + 2 + i) begin errors++; $display("[TB] FAIL single_cycle%0d: got %0d expected %0d", i, out_log[i].cyc, c0 + 2 + i); end
    end
  endtask

  task automatic test_round_robin();
    int c0;
    int p;
    beat_t e;
    do_reset();
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < N; k++)
        for (int b = 0; b < 2; b++)
          src_q[k].push_back(mk(64'h1000 + 64'(k * 256 + n * 16 + b), b == 0, b == 1, 3'(k), 10'(k + 1)));
    step();
    c0 = cyc;
    for (int t = 0; t < 80 && out_log.size() < 16; t++) step();
    checks++; if (out_log.size() != 16) begin errors++; $display("[TB] FAIL rr_count: got %0d beats expected 16", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 16; i++) begin
      p = i / 2;
      e = mk(64'h1000 + 64'((p % 4) * 256 + (p / 4) * 16 + (i % 2)), (i % 2) == 0, (i % 2) == 1, 3'(p % 4), 10'((p % 4) + 1));
      checks++; if (out_log[i].dir != p % 4) begin errors++; $display("[TB] FAIL rr_dir%0d: got %0d expected %0d", i, out_log[i].dir, p % 4); end
      checks++; if (out_log[i].b !== e) begin errors++; $display("[TB] FAIL rr_beat%0d: got %h expected %h", i, out_log[i].b, e); end
      checks++; if (out_log[i].cyc != c0 + 2 + 3 * p + (i % 2)) begin errors++; $display("[TB] FAIL rr_cycle%0d: got %0d expected %0d", i, out_log[i].cyc, c0 + 2 + 3 * p + (i % 2)); end
    end
  endtask

  task automatic test_backpressure();
    int c0;
    int r;
    int exp_cyc [4];
    beat_t e;
    exp_cyc = '{2, 5, 6, 7};
    out_log.delete();
    for (int i = 0; i < 4; i++)
      src_q[1].push_back(mk(64'hB0 + 64'(i), i == 0, i == 3, (i == 3) ? 3'd5 : 3'd0, 10'd7));
    step();
    c0 = cyc;
    for (int t = 0; t < 30 && out_log.size() < 4; t++) begin
      step();
      r = cyc - c0;
      ast_ready_i = (r == 3 || r == 4) ? 1'b0 : 1'b1;
      #1;
      if (r == 3 || r == 4) begin
        checks++; if (ast_valid_o !== 1'b1 || ast_data_o !== 64'hB1) begin errors++; $display("[TB] FAIL bp_hold_r%0d: got valid %b data %h expected valid 1 data b1", r, ast_valid_o, ast_data_o); end
        checks++; if (ast_ready_o[1] !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_r%0d: got %b expected 0", r, ast_ready_o[1]); end
      end
    end
    ast_ready_i = 1'b1;
    checks++; if (out_log.size() != 4) begin errors++; $display("[TB] FAIL bp_count: got %0d beats expected 4", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 4; i++) begin
      e = mk(64'hB0 + 64'(i), i == 0, i == 3, (i == 3) ? 3'd5 : 3'd0, 10'd7);
      checks++; if (out_log[i].b !== e || out_log[i].dir != 1) begin errors++; $display("[TB] FAIL bp_beat%0d: got %h dir %0d expected %h dir 1", i, out_log[i].b, out_log[i].dir, e); end
      checks++; if (out_log[i].cyc != c0 + exp_cyc[i]) begin errors++; $display("[TB] FAIL bp_cycle%0d: got %0d expected %0d", i, out_log[i].cyc, c0 + exp_cyc[i]); end
    end
  endtask

  task automatic test_single_beat();
    int c0;
    do_reset();
    src_q[1].push_back(mk(64'h11, 1'b1, 1'b1, 3'd1, 10'd11));
    src_q[3].push_back(mk(64'h33, 1'b1, 1'b1, 3'd3, 10'd33));
    step();
    c0 = cyc;
    for (int t = 0; t < 20 && out_log.size() < 2; t++) step();
    checks++; if (out_log.size() != 2) begin errors++; $display("[TB] FAIL sb_count: got %0d beats expected 2", out_log.size()); end
    if (out_log.size() >= 2) begin
      checks++; if (out_log[0].dir != 1 || out_log[0].b !== mk(64'h11, 1'b1, 1'b1, 3'd1, 10'd11)) begin errors++; $display("[TB] FAIL sb_first: got dir %0d beat %h expected dir 1 data 11", out_log[0].dir, out_log[0].b); end
      checks++; if (out_log[1].dir != 3 || out_log[1].b !== mk(64'h33, 1'b1, 1'b1, 3'd3, 10'd33)) begin errors++; $display("[TB] FAIL sb_second: got dir %0d beat %h expected dir 3 data 33", out_log[1].dir, out_log[1].b); end
      checks++; if (out_log[0].cyc != c0 + 2 || out_log[1].cyc != c0 + 4) begin errors++; $display("[TB] FAIL sb_cycles: got %0d,%0d expected %0d,%0d", out_log[0].cyc, out_log[1].cyc, c0 + 2, c0 + 4); end
    end
  endtask

  task automatic test_mid_packet_reset();
    beat_t e;
    out_log.delete();
    for (int i = 0; i < 5; i++)
      src_q[0].push_back(mk(64'hC0 + 64'(i), i == 0, i == 4, 3'd0, 10'd2));
    step();
    step();
    step();
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    src_q[0].delete();
    ast_valid_i[0] = 1'b0;
    drove_idle[0]  = 1'b0;
    #1;
    checks++; if (ast_valid_o !== 1'b0 || dir_o !== '0 || ast_data_o !== '0) begin errors++; $display("[TB] FAIL mrst_out: got valid %b dir %0d data %h expected 0/0/0", ast_valid_o, dir_o, ast_data_o); end
    for (int k = 0; k < N; k++) begin
      checks++; if (ast_ready_o[k] !== 1'b0) begin errors++; $display("[TB] FAIL mrst_ready[%0d]: got %b expected 0", k, ast_ready_o[k]); end
    end
    checks++; if (out_log.size() != 1) begin errors++; $display("[TB] FAIL mrst_drained: got %0d beats expected 1", out_log.size()); end
    out_log.delete();
    for (int i = 0; i < 3; i++)
      src_q[0].push_back(mk(64'hD0 + 64'(i), i == 0, i == 2, 3'd4, 10'd1));
    src_q[3].push_back(mk(64'hE0, 1'b1, 1'b1, 3'd6, 10'd3));
    step();
    for (int t = 0; t < 40 && out_log.size() < 4; t++) step();
    checks++; if (out_log.size() != 4) begin errors++; $display("[TB] FAIL mrst_fresh_count: got %0d beats expected 4", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 4; i++) begin
      e = (i < 3) ? mk(64'hD0 + 64'(i), i == 0, i == 2, 3'd4, 10'd1) : mk(64'hE0, 1'b1, 1'b1, 3'd6, 10'd3);
      checks++; if (out_log[i].b !== e || out_log[i].dir != ((i < 3) ? 0 : 3)) begin errors++; $display("[TB] FAIL mrst_fresh%0d: got %h dir %0d expected %h dir %0d", i, out_log[i].b, out_log[i].dir, e, (i < 3) ? 0 : 3); end
    end
  endtask

  task automatic test_random();
    int    len;
    bit    done;
    bit    in_pkt;
    int    cur_dir;
    rec_t  r;
    beat_t e;
    beat_t b;
    do_reset();
    in_pkt  = 1'b0;
    cur_dir = 0;
    for (int run = 0; run < 10; run++) begin
      for (int k = 0; k < N; k++) begin
        for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
          len = int'($urandom_range(1, 10));
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) src_q[k].push_back(gap_beat());
            b = mk({$urandom, $urandom}, i == 0, i == len - 1, 3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)));
            src_q[k].push_back(b);
            exp_q[k].push_back(b);
          end
        end
      end
      done = 1'b0;
      for (int t = 0; t < 3000 && !done; t++) begin
        step();
        ast_ready_i = ($urandom_range(0, 3) != 0);
        while (out_log.size() > 0) begin
          r = out_log.pop_front();
          checks++;
          if (in_pkt && r.dir != cur_dir) begin errors++; $display("[TB] FAIL rand_interleave: got dir %0d expected %0d", r.dir, cur_dir); end
          in_pkt  = !r.b.eop;
          cur_dir = r.dir;
          checks++;
          if (exp_q[r.dir].size() == 0) begin
            errors++; $display("[TB] FAIL rand_extra: got beat %h on dir %0d expected none", r.b, r.dir);
          end else begin
            e = exp_q[r.dir].pop_front();
            if (r.b !== e) begin errors++; $display("[TB] FAIL rand_beat run%0d dir%0d: got %h expected %h", run, r.dir, r.b, e); end
          end
        end
        done = 1'b1;
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0 || exp_q[k].size() != 0) done = 1'b0;
      end
      checks++; if (!done) begin errors++; $display("[TB] FAIL rand_drain run%0d: got undrained traffic expected all packets delivered", run); end
      ast_ready_i = 1'b1;
      for (int k = 0; k < N; k++) begin
        src_q[k].delete();
        exp_q[k].delete();
      end
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    srst_i      = 1'b0;
    ast_ready_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      ast_data_i[k]          = '0;
      ast_startofpacket_i[k] = 1'b0;
      ast_endofpacket_i[k]   = 1'b0;
      ast_valid_i[k]         = 1'b0;
      ast_empty_i[k]         = '0;
      ast_channel_i[k]       = '0;
      acc[k]                 = 1'b0;
      drove_idle[k]          = 1'b0;
    end
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_single_beat();
    test_mid_packet_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
